// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: steers the hps ioctl ROM stream into core regions, holds game reset, validates image size.
// Optional BRUBBR_LOAD_CHECKSUM_EN adds a load_sum output (16-bit sum of forwarded bytes).
module rom_load_sequencer #(
  parameter logic [16:0] CPU_END       = 17'h0C000,
  parameter logic [16:0] GFX_END       = 17'h16000,
  parameter logic [16:0] SND_END       = 17'h18000,
  parameter logic [16:0] TOTAL_SIZE    = 17'h18020,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [7:0]  ROM_INDEX     = 8'd0
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  dn_region,
  output logic        game_reset,
  output logic        load_done,
  output logic        load_err
`ifdef BRUBBR_LOAD_CHECKSUM_EN
  ,output logic [15:0] load_sum
`endif
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [24:0] TOTAL_W = 25'(TOTAL_SIZE);
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
  state_t state, state_nx;
  logic [17:0] byte_cnt;
  logic [SW-1:0] settle_cnt;
  logic err_oob, dl, wr_acc, fwd, settle_end, enter_load, image_ok;
  assign dl = ioctl_download && ioctl_index == ROM_INDEX;
  assign wr_acc = state == LOAD && dl && ioctl_wr;
  assign fwd = wr_acc && ioctl_addr < TOTAL_W;
  assign settle_end = state == SETTLE && settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign enter_load = state != LOAD && state_nx == LOAD;
  assign image_ok = byte_cnt == 18'(TOTAL_SIZE) && !err_oob;
  always_ff @(posedge clock_12)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == LOAD) state_nx = ioctl_download ? LOAD : SETTLE;
    else if (dl) state_nx = LOAD;
    else if (settle_end) state_nx = RUN;
  end
  always_comb begin
    dn_region = !dn_wr ? 4'b0000 :
                dn_addr < CPU_END ? 4'b0001 :
                dn_addr < GFX_END ? 4'b0010 :
                dn_addr < SND_END ? 4'b0100 : 4'b1000;
    game_reset = !(state == RUN && load_done);
  end
  always_ff @(posedge clock_12)
    if (reset) begin
      dn_addr <= '0;
      dn_data <= '0;
      dn_wr <= 1'b0;
      byte_cnt <= '0;
      settle_cnt <= '0;
      err_oob <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      dn_wr <= fwd;
      settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
      if (fwd) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
      if (enter_load) begin
        byte_cnt <= '0;
        err_oob <= 1'b0;
        load_done <= 1'b0;
        load_err <= 1'b0;
      end else if (wr_acc) begin
        byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 18'd1;
        err_oob <= err_oob | !fwd;
      end
      if (settle_end && state_nx == RUN) begin
        load_done <= image_ok;
        load_err <= !image_ok;
      end
    end
`ifdef BRUBBR_LOAD_CHECKSUM_EN
  always_ff @(posedge clock_12)
    if (reset) load_sum <= '0;
    else load_sum <= enter_load ? 16'h0000 : fwd ? load_sum + {8'h00, ioctl_dout} : load_sum;
`endif
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed checks of the ROM load sequencer using a scaled-down image map.
module tb_rom_load_sequencer;
  localparam logic [16:0] TOT = 17'h001A0;
  logic clock_12 = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic [16:0] dn_addr;
  logic [7:0] dn_data;
  logic dn_wr, game_reset, load_done, load_err;
  logic [3:0] dn_region;
  int checks = 0, errors = 0;
`ifdef BRUBBR_LOAD_CHECKSUM_EN
  logic [15:0] load_sum;
`endif
  rom_load_sequencer #(
    .CPU_END(17'h000C0), .GFX_END(17'h00160), .SND_END(17'h00180),
    .TOTAL_SIZE(TOT), .SETTLE_CYCLES(16), .ROM_INDEX(8'd0)
  ) dut (
    .clock_12(clock_12), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_region(dn_region),
    .game_reset(game_reset), .load_done(load_done), .load_err(load_err)
`ifdef BRUBBR_LOAD_CHECKSUM_EN
    , .load_sum(load_sum)
`endif
  );
  always #5 clock_12 = ~clock_12;
  task automatic tick;
    @(posedge clock_12);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] region_at(input int i);
    case (i)
      'hBF: return 4'b0001;
      'hC0, 'h15F: return 4'b0010;
      'h160, 'h17F: return 4'b0100;
      'h180, 'h19F: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit fwd);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick;
    ioctl_wr = 1'b0;
    if (fwd) check("fwd", 32'({dn_wr, dn_addr, dn_data}), 32'({1'b1, a[16:0], d}));
    else check("nofwd", 32'(dn_wr), 32'd0);
  endtask
  task automatic load_image(input int n, input bit pad);
    logic [7:0] tbl [4] = '{8'hFF, 8'h01, 8'h80, 8'h80};
    logic [3:0] r;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick;
    check("enter_rst", 32'(game_reset), 32'd1);
    check("enter_flags", 32'({load_done, load_err}), 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(25'(i), pad ? (i < 4 ? tbl[i] : 8'h00) : 8'(i), 1'b1);
      r = region_at(i);
      if (r != 4'b0000) check("region", 32'(dn_region), 32'(r));
    end
  endtask
  task automatic end_download(input bit ok);
    int early = 0;
    ioctl_download = 1'b0;
    tick;
    repeat (15) begin
      tick;
      if (!game_reset) early++;
    end
    check("settle_hold", early, 0);
    tick;
    check("run_rst", 32'(game_reset), 32'(!ok));
    check("done_err", 32'({load_done, load_err}), ok ? 32'd2 : 32'd1);
  endtask
  initial begin
    int n;
    tick;
    tick;
    check("rst_dn", 32'({dn_wr, dn_region, dn_addr}), 32'd0);
    check("rst_data", 32'(dn_data), 32'd0);
    check("rst_out", 32'({game_reset, load_done, load_err}), 32'b100);
    reset = 1'b0;
    load_image(int'(TOT), 1'b0);
    end_download(1'b1);
    n = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      tick;
      ioctl_wr = 1'b0;
      if (dn_wr || game_reset) n++;
    end
    ioctl_download = 1'b0;
    repeat (20) begin
      tick;
      if (game_reset) n++;
    end
    check("idx1_ignored", n, 0);
    check("idx1_done", 32'(load_done), 32'd1);
    ioctl_index = 8'd0;
    send_byte(25'h10, 8'h55, 1'b0);
    check("nodl_run", 32'(game_reset), 32'd0);
    load_image(int'(17'h00180), 1'b0);
    end_download(1'b0);
    n = 0;
    repeat (50) begin
      tick;
      if (!game_reset) n++;
    end
    check("short_hold", n, 0);
    load_image(int'(TOT), 1'b0);
    send_byte(25'(TOT), 8'hAA, 1'b0);
    end_download(1'b0);
    load_image(int'(TOT) - 1, 1'b0);
    send_byte(25'h100019F, 8'h9F, 1'b0);
    end_download(1'b0);
    ioctl_download = 1'b1;
    tick;
    end_download(1'b0);
    load_image(100, 1'b0);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd100;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    check("midrst_wr", 32'(dn_wr), 32'd0);
    check("midrst_out", 32'({game_reset, load_done, load_err}), 32'b100);
    n = 0;
    repeat (20) begin
      tick;
      if (!game_reset || load_done || load_err) n++;
    end
    check("midrst_idle", n, 0);
    load_image(int'(TOT), 1'b0);
    end_download(1'b1);
`ifdef BRUBBR_LOAD_CHECKSUM_EN
    load_image(int'(TOT), 1'b1);
    end_download(1'b1);
    check("load_sum", 32'(load_sum), 32'h0200);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
